// File: rtl/intr_ctrl_if.sv
// Control-unit side of the 8085 interrupt arbiter: boundary strobe, ack,
// EI/DI/SIM pulses, and the presented request / RIM read-back.
interface intr_ctrl_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 16
);
    logic                sample;
    logic                ack;
    logic                ei;
    logic                di;
    logic                sim_we;
    logic [DATASIZE-1:0] acc;
    logic                irq;
    logic [ADDRSIZE-1:0] ivec;
    logic                inta_cyc;
    logic                inte;
    logic [DATASIZE-1:0] rim_data;

    modport master (
        output sample, ack, ei, di, sim_we, acc,
        input  irq, ivec, inta_cyc, inte, rim_data
    );

    modport slave (
        input  sample, ack, ei, di, sim_we, acc,
        output irq, ivec, inta_cyc, inte, rim_data
    );
endinterface

// File: rtl/intr_ctrl.sv
// 8085 interrupt arbiter: latches TRAP/RST7.5 edges, qualifies level requests,
// presents one prioritised request per instruction boundary and holds it until ack.
//
// state | meaning
// IDLE  | no request presented; a qualified request is granted on sample
// PEND  | irq/ivec/inta_cyc frozen until control acknowledges
module intr_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_i,
    input  logic        rst75_i,
    input  logic        rst65_i,
    input  logic        rst55_i,
    input  logic        intr_i,
    input  logic        sid_i,
    output logic        sod_o,
    intr_ctrl_if.slave  ctl
);
    typedef enum logic {IDLE, PEND} state_e;
    typedef enum logic [2:0] {SRC_TRAP, SRC_R75, SRC_R65, SRC_R55, SRC_INTR} src_e;

    state_e              state_q;
    src_e                win_q;
    logic                trap_pin_q, r75_pin_q;
    logic                trap_ff_q, ff75_q;
    logic                trap_ff_d, ff75_d;
    logic [2:0]          mask_q;
    logic                inte_q, ei_pend_q, sod_q;
    logic                irq_q, inta_q;
    logic [ADDRSIZE-1:0] ivec_q;

    logic trap_edge, r75_edge, mask_ok, sample_ok, ack_ok;
    logic req_trap, req_75, req_65, req_55, req_intr, req_any;
    logic clr_trap, clr_75;

    assign trap_edge = trap_i & ~trap_pin_q;
    assign r75_edge  = rst75_i & ~r75_pin_q;
    // The sample that consumes a pending EI turns INTE on but grants only TRAP.
    assign mask_ok   = inte_q & ~ei_pend_q;
    assign sample_ok = (state_q == IDLE) & ctl.sample;
    assign ack_ok    = (state_q == PEND) & ctl.ack;

    assign req_trap = trap_ff_q & trap_i;
    assign req_75   = ff75_q & ~mask_q[2] & mask_ok;
    assign req_65   = rst65_i & ~mask_q[1] & mask_ok;
    assign req_55   = rst55_i & ~mask_q[0] & mask_ok;
    assign req_intr = intr_i & mask_ok;
    assign req_any  = req_trap | req_75 | req_65 | req_55 | req_intr;

    assign clr_trap = ack_ok & (win_q == SRC_TRAP);
    assign clr_75   = (ctl.sim_we & ctl.acc[4]) | (ack_ok & (win_q == SRC_R75));
    // A fresh edge always beats a clear in the same cycle.
    assign trap_ff_d = trap_edge | (trap_ff_q & ~clr_trap);
    assign ff75_d    = r75_edge | (ff75_q & ~clr_75);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= SRC_TRAP;
            trap_pin_q <= 1'b0;
            r75_pin_q  <= 1'b0;
            trap_ff_q  <= 1'b0;
            ff75_q     <= 1'b0;
            mask_q     <= 3'b111;
            inte_q     <= 1'b0;
            ei_pend_q  <= 1'b0;
            sod_q      <= 1'b0;
            irq_q      <= 1'b0;
            inta_q     <= 1'b0;
            ivec_q     <= '0;
        end else begin
            trap_pin_q <= trap_i;
            r75_pin_q  <= rst75_i;
            trap_ff_q  <= trap_ff_d;
            ff75_q     <= ff75_d;

            if (ctl.sim_we) begin
                if (ctl.acc[3]) mask_q <= ctl.acc[2:0];
                if (ctl.acc[6]) sod_q  <= ctl.acc[7];
            end

            // Later assignments take precedence: DI over ack over EI/sample.
            if (sample_ok && ei_pend_q) begin
                inte_q    <= 1'b1;
                ei_pend_q <= 1'b0;
            end
            if (ctl.ei) ei_pend_q <= 1'b1;
            if (ack_ok) begin
                inte_q    <= 1'b0;
                ei_pend_q <= 1'b0;
            end
            if (ctl.di) begin
                inte_q    <= 1'b0;
                ei_pend_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (sample_ok && req_any) begin
                        irq_q   <= 1'b1;
                        state_q <= PEND;
                        inta_q  <= 1'b0;
                        if (req_trap) begin
                            win_q  <= SRC_TRAP;
                            ivec_q <= ADDRSIZE'(16'h0024);
                        end else if (req_75) begin
                            win_q  <= SRC_R75;
                            ivec_q <= ADDRSIZE'(16'h003C);
                        end else if (req_65) begin
                            win_q  <= SRC_R65;
                            ivec_q <= ADDRSIZE'(16'h0034);
                        end else if (req_55) begin
                            win_q  <= SRC_R55;
                            ivec_q <= ADDRSIZE'(16'h002C);
                        end else begin
                            win_q  <= SRC_INTR;
                            ivec_q <= '0;
                            inta_q <= 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (ctl.ack) begin
                        irq_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ctl.irq      = irq_q;
    assign ctl.ivec     = ivec_q;
    assign ctl.inta_cyc = inta_q;
    assign ctl.inte     = inte_q;
    assign ctl.rim_data = DATASIZE'({sid_i, ff75_q, rst65_i, rst55_i, inte_q, mask_q});
    assign sod_o        = sod_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed sequence then random traffic, every cycle
// compared against a source-table reference model of the interrupt rules.
module tb_intr_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trap = 1'b0, rst75 = 1'b0, rst65 = 1'b0, rst55 = 1'b0, intr = 1'b0, sid = 1'b0;
    logic sod;

    intr_ctrl_if #(.DATASIZE(8), .ADDRSIZE(16)) bus ();

    intr_ctrl #(.DATASIZE(8), .ADDRSIZE(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .trap_i  (trap),
        .rst75_i (rst75),
        .rst65_i (rst65),
        .rst55_i (rst55),
        .intr_i  (intr),
        .sid_i   (sid),
        .sod_o   (sod),
        .ctl     (bus.master)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sources indexed by priority (0 = TRAP ... 4 = INTR).
    logic [15:0] vec_tab [5] = '{16'h0024, 16'h003C, 16'h0034, 16'h002C, 16'h0000};
    bit       m_trap_prev, m_r75_prev, m_trap_pend, m_p75;
    bit [2:0] m_mask;
    bit       m_inte, m_eipend, m_sod, m_busy, m_inta;
    int       m_src;
    logic [15:0] m_vec;

    task automatic model_reset();
        m_trap_prev = 0; m_r75_prev = 0; m_trap_pend = 0; m_p75 = 0;
        m_mask = 3'b111; m_inte = 0; m_eipend = 0; m_sod = 0;
        m_busy = 0; m_inta = 0; m_src = 0; m_vec = 16'h0000;
    endtask

    task automatic model_step();
        bit req [5];
        int win;
        bit en, grant, acking, e_trap, e_75, eip;
        if (rst) begin
            model_reset();
            return;
        end
        e_trap = trap && !m_trap_prev;
        e_75   = rst75 && !m_r75_prev;
        en     = m_inte && !m_eipend;
        req[0] = m_trap_pend && trap;
        req[1] = m_p75 && !m_mask[2] && en;
        req[2] = rst65 && !m_mask[1] && en;
        req[3] = rst55 && !m_mask[0] && en;
        req[4] = intr && en;
        win = -1;
        for (int i = 4; i >= 0; i--) if (req[i]) win = i;
        grant  = !m_busy && bus.sample && (win >= 0);
        acking = m_busy && bus.ack;

        m_trap_pend = e_trap || (m_trap_pend && !(acking && m_src == 0));
        m_p75 = e_75 || (m_p75 && !(bus.sim_we && bus.acc[4]) && !(acking && m_src == 1));
        if (bus.sim_we && bus.acc[3]) m_mask = bus.acc[2:0];
        if (bus.sim_we && bus.acc[6]) m_sod = bus.acc[7];

        eip = m_eipend;
        if (bus.di || acking) begin
            m_inte = 0;
            m_eipend = 0;
        end else begin
            if (!m_busy && bus.sample && eip) begin
                m_inte = 1;
                m_eipend = 0;
            end
            if (bus.ei) m_eipend = 1;
        end

        if (grant) begin
            m_busy = 1;
            m_src  = win;
            m_vec  = vec_tab[win];
            m_inta = (win == 4);
        end else if (acking) begin
            m_busy = 0;
        end
        m_trap_prev = trap;
        m_r75_prev  = rst75;
    endtask

    task automatic cyc();
        logic [7:0] exp_rim;
        @(posedge clk);
        model_step();
        #1;
        exp_rim = {sid, m_p75, rst65, rst55, m_inte, m_mask};
        check_eq("irq", 32'(bus.irq), 32'(m_busy));
        check_eq("inte", 32'(bus.inte), 32'(m_inte));
        check_eq("rim", 32'(bus.rim_data), 32'(exp_rim));
        check_eq("sod", 32'(sod), 32'(m_sod));
        if (m_busy) begin
            check_eq("ivec", 32'(bus.ivec), 32'(m_vec));
            check_eq("inta", 32'(bus.inta_cyc), 32'(m_inta));
        end
    endtask

    task automatic pulse_ei();
        bus.ei = 1; cyc(); bus.ei = 0;
    endtask

    task automatic do_sim(input logic [7:0] a);
        bus.sim_we = 1; bus.acc = a; cyc(); bus.sim_we = 0; bus.acc = 8'h00;
    endtask

    task automatic do_sample();
        bus.sample = 1; cyc(); bus.sample = 0;
    endtask

    task automatic do_ack();
        bus.ack = 1; cyc(); bus.ack = 0;
    endtask

    initial begin
        bus.sample = 0; bus.ack = 0; bus.ei = 0; bus.di = 0; bus.sim_we = 0; bus.acc = 8'h00;
        model_reset();
        #1;
        cyc(); cyc();
        rst = 0;
        check_eq("rst_irq", 32'(bus.irq), 32'h0);

        for (int i = 0; i < 4; i++) begin do_sample(); cyc(); end
        check_eq("idle_rim", 32'(bus.rim_data), 32'h07);
        check_eq("idle_inte", 32'(bus.inte), 32'h0);
        check_eq("idle_sod", 32'(sod), 32'h0);

        // EI then RST6.5: first sample only enables
        pulse_ei();
        do_sim(8'h08);
        rst65 = 1;
        do_sample();
        check_eq("ei_nogrant", 32'(bus.irq), 32'h0);
        do_sample();
        check_eq("r65_irq", 32'(bus.irq), 32'h1);
        check_eq("r65_vec", 32'(bus.ivec), 32'h0034);
        check_eq("r65_inta", 32'(bus.inta_cyc), 32'h0);
        do_ack();
        check_eq("r65_ackirq", 32'(bus.irq), 32'h0);
        check_eq("r65_ackinte", 32'(bus.inte), 32'h0);
        rst65 = 0;

        // RST7.5 beats RST5.5 and INTR; then RST5.5; then INTR
        pulse_ei(); do_sample();
        rst75 = 1; rst55 = 1; intr = 1; cyc();
        do_sample();
        check_eq("r75_vec", 32'(bus.ivec), 32'h003C);
        do_ack(); rst75 = 0;
        pulse_ei(); do_sample(); do_sample();
        check_eq("r55_vec", 32'(bus.ivec), 32'h002C);
        rst55 = 0; do_ack();
        pulse_ei(); do_sample(); do_sample();
        check_eq("intr_inta", 32'(bus.inta_cyc), 32'h1);
        check_eq("intr_vec", 32'(bus.ivec), 32'h0000);
        do_ack(); intr = 0;

        // TRAP with INTE off, then a TRAP pulse that falls before sample
        bus.di = 1; cyc(); bus.di = 0;
        trap = 1; cyc(); do_sample();
        check_eq("trap_irq", 32'(bus.irq), 32'h1);
        check_eq("trap_vec", 32'(bus.ivec), 32'h0024);
        do_ack(); trap = 0; cyc();
        trap = 1; cyc(); trap = 0; cyc(); do_sample();
        check_eq("trap_short", 32'(bus.irq), 32'h0);

        // Masked RST7.5 latch and SIM clear set-over-clear
        do_sim(8'h0C);
        rst75 = 1; cyc(); rst75 = 0; cyc();
        check_eq("r75_latch", 32'(bus.rim_data[6]), 32'h1);
        do_sample();
        check_eq("r75_masked", 32'(bus.irq), 32'h0);
        rst75 = 1; do_sim(8'h10); rst75 = 0;
        check_eq("r75_setwin", 32'(bus.rim_data[6]), 32'h1);
        cyc(); do_sim(8'h10);
        check_eq("r75_clr", 32'(bus.rim_data[6]), 32'h0);

        // SOD, then reset while pending
        do_sim(8'hC0);
        check_eq("sod_set", 32'(sod), 32'h1);
        do_sim(8'h80);
        check_eq("sod_hold", 32'(sod), 32'h1);
        pulse_ei(); do_sample(); do_sim(8'h08);
        rst65 = 1; do_sample();
        check_eq("pend_irq", 32'(bus.irq), 32'h1);
        rst = 1; cyc(); rst = 0;
        check_eq("rstpend_irq", 32'(bus.irq), 32'h0);
        check_eq("rstpend_mask", 32'(bus.rim_data[2:0]), 32'h7);
        rst65 = 0; cyc();

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) trap = ~trap;
            if ($urandom_range(0, 5) == 0) rst75 = ~rst75;
            if ($urandom_range(0, 9) == 0) rst65 = ~rst65;
            if ($urandom_range(0, 9) == 0) rst55 = ~rst55;
            if ($urandom_range(0, 9) == 0) intr = ~intr;
            sid        = 1'($urandom_range(0, 1));
            bus.sample = ($urandom_range(0, 2) == 0);
            bus.ack    = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            bus.ei     = ($urandom_range(0, 9) == 0);
            bus.di     = ($urandom_range(0, 24) == 0);
            bus.sim_we = ($urandom_range(0, 11) == 0);
            bus.acc    = 8'($urandom);
            rst        = ($urandom_range(0, 599) == 0);
            cyc();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
